// File: rtl/pipe_lsu_pkg.sv
// rtl/pipe_lsu_pkg.sv - shared constants, types and helpers for the MEM-stage load/store unit
package pipe_lsu_pkg;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    localparam logic [1:0] EXC_MISALIGN = 2'b00;
    localparam logic [1:0] EXC_RANGE    = 2'b01;
    localparam logic [1:0] EXC_ILLEGAL  = 2'b10;
    localparam logic [1:0] EXC_TIMEOUT  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_REQ  = 2'b01,
        S_RESP = 2'b10,
        S_DONE = 2'b11
    } lsu_state_e;

    // Byte-enable pattern for an access of 1/2/4/8 bytes, before lane shift.
    function automatic logic [7:0] size_mask(input logic [1:0] sz);
        case (sz)
            2'b00:   size_mask = 8'h01;
            2'b01:   size_mask = 8'h03;
            2'b10:   size_mask = 8'h0F;
            default: size_mask = 8'hFF;
        endcase
    endfunction

    // Low address bits that must be zero for a naturally aligned access.
    function automatic logic [2:0] align_mask(input logic [1:0] sz);
        case (sz)
            2'b00:   align_mask = 3'b000;
            2'b01:   align_mask = 3'b001;
            2'b10:   align_mask = 3'b011;
            default: align_mask = 3'b111;
        endcase
    endfunction

endpackage

// File: rtl/pipe_lsu_align.sv
// rtl/pipe_lsu_align.sv - byte-lane steering for stores and lane extraction/extension for loads
//
// Ports:
//   f3_i       access width/sign encoding
//   off_i      byte offset within the doubleword (ea[2:0])
//   st_data_i  store data, right-justified
//   ld_raw_i   raw doubleword returned by memory
//   be_o       byte enables for the access
//   st_lane_o  store data shifted into its byte lanes
//   ld_ext_o   load result, right-justified and sign/zero-extended
module lsu_align
    import pipe_lsu_pkg::*;
(
    input  logic [2:0]  f3_i,
    input  logic [2:0]  off_i,
    input  logic [63:0] st_data_i,
    input  logic [63:0] ld_raw_i,
    output logic [7:0]  be_o,
    output logic [63:0] st_lane_o,
    output logic [63:0] ld_ext_o
);

    logic [5:0]  bit_off;
    logic [63:0] lane;

    assign bit_off   = {off_i, 3'b000};
    assign be_o      = size_mask(f3_i[1:0]) << off_i;
    assign st_lane_o = st_data_i << bit_off;
    assign lane      = ld_raw_i >> bit_off;

    always_comb begin
        ld_ext_o = '0;
        case (f3_i)
            F3_B:    ld_ext_o = {{56{lane[7]}},  lane[7:0]};
            F3_H:    ld_ext_o = {{48{lane[15]}}, lane[15:0]};
            F3_W:    ld_ext_o = {{32{lane[31]}}, lane[31:0]};
            F3_D:    ld_ext_o = lane;
            F3_BU:   ld_ext_o = {56'd0, lane[7:0]};
            F3_HU:   ld_ext_o = {48'd0, lane[15:0]};
            F3_WU:   ld_ext_o = {32'd0, lane[31:0]};
            default: ld_ext_o = '0;
        endcase
    end

endmodule

// File: rtl/pipe_lsu.sv
// rtl/pipe_lsu.sv - MEM-stage load/store initiator with req/gnt/rvalid handshake and stall
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   ex_valid/ex_ready          instruction handoff from EX/MEM
//   op, f3, rs1, rs2, imm12    opcode, width/sign, base, store data, offset
//   rd_idx                     load destination register
//   mem_req/mem_gnt            request handshake to doubleword memory
//   mem_we/mem_addr/mem_be     store flag, dword index, byte enables
//   mem_wdata                  lane-aligned store data
//   mem_rvalid/mem_rdata       load response
//   stall                      hold upstream stages while busy
//   wb_valid/wb_rd_idx/wb_data one-cycle load writeback
//   exc_valid/exc_cause/exc_addr one-cycle exception report
module pipe_lsu
    import pipe_lsu_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [6:0]        op,
    input  logic [2:0]        f3,
    input  logic [63:0]       rs1,
    input  logic [63:0]       rs2,
    input  logic [11:0]       imm12,
    input  logic [4:0]        rd_idx,
    output logic              mem_req,
    input  logic              mem_gnt,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_be,
    output logic [63:0]       mem_wdata,
    input  logic              mem_rvalid,
    input  logic [63:0]       mem_rdata,
    output logic              stall,
    output logic              wb_valid,
    output logic [4:0]        wb_rd_idx,
    output logic [63:0]       wb_data,
    output logic              exc_valid,
    output logic [1:0]        exc_cause,
    output logic [63:0]       exc_addr
);

    localparam int              CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    lsu_state_e       state_q;
    logic [63:0]      ea_q;
    logic [2:0]       f3_q;
    logic [63:0]      rs2_q;
    logic [4:0]       rd_q;
    logic             is_store_q;
    logic             mem_req_q;
    logic [CNT_W-1:0] cnt_q;
    logic             wb_valid_q;
    logic [4:0]       wb_rd_idx_q;
    logic [63:0]      wb_data_q;
    logic             exc_valid_q;
    logic [1:0]       exc_cause_q;
    logic [63:0]      exc_addr_q;

    logic        is_load;
    logic        is_store;
    logic        accept;
    logic [63:0] ea_d;
    logic        illegal_d;
    logic        misal_d;
    logic        oor_d;
    logic        fault_d;
    logic [1:0]  cause_d;

    logic [7:0]  be_w;
    logic [63:0] wdata_w;
    logic [63:0] ld_ext_w;

    assign is_load  = (op == OP_LOAD);
    assign is_store = (op == OP_STORE);
    assign accept   = (state_q == S_IDLE) && ex_valid && (is_load || is_store);

    assign ea_d      = rs1 + {{52{imm12[11]}}, imm12};
    assign illegal_d = is_load ? (f3 == 3'b111) : f3[2];
    assign misal_d   = |(ea_d[2:0] & align_mask(f3[1:0]));
    assign oor_d     = |ea_d[63:ADDR_W+3];

    // Illegal width outranks misalignment, which outranks range.
    always_comb begin
        fault_d = 1'b1;
        cause_d = EXC_ILLEGAL;
        if (illegal_d) begin
            cause_d = EXC_ILLEGAL;
        end else if (misal_d) begin
            cause_d = EXC_MISALIGN;
        end else if (oor_d) begin
            cause_d = EXC_RANGE;
        end else begin
            fault_d = 1'b0;
        end
    end

    lsu_align u_align (
        .f3_i      (f3_q),
        .off_i     (ea_q[2:0]),
        .st_data_i (rs2_q),
        .ld_raw_i  (mem_rdata),
        .be_o      (be_w),
        .st_lane_o (wdata_w),
        .ld_ext_o  (ld_ext_w)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            ea_q        <= '0;
            f3_q        <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            is_store_q  <= 1'b0;
            mem_req_q   <= 1'b0;
            cnt_q       <= '0;
            wb_valid_q  <= 1'b0;
            wb_rd_idx_q <= '0;
            wb_data_q   <= '0;
            exc_valid_q <= 1'b0;
            exc_cause_q <= '0;
            exc_addr_q  <= '0;
        end else begin
            wb_valid_q  <= 1'b0;
            exc_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        ea_q       <= ea_d;
                        f3_q       <= f3;
                        rs2_q      <= rs2;
                        rd_q       <= rd_idx;
                        is_store_q <= is_store;
                        cnt_q      <= '0;
                        if (fault_d) begin
                            exc_valid_q <= 1'b1;
                            exc_cause_q <= cause_d;
                            exc_addr_q  <= ea_d;
                            state_q     <= S_DONE;
                        end else begin
                            mem_req_q <= 1'b1;
                            state_q   <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    // A grant on the final waiting cycle still wins over the timeout.
                    if (mem_gnt) begin
                        mem_req_q <= 1'b0;
                        cnt_q     <= '0;
                        state_q   <= is_store_q ? S_DONE : S_RESP;
                    end else if (cnt_q == TO_LAST) begin
                        mem_req_q   <= 1'b0;
                        exc_valid_q <= 1'b1;
                        exc_cause_q <= EXC_TIMEOUT;
                        exc_addr_q  <= ea_q;
                        state_q     <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_RESP: begin
                    if (mem_rvalid) begin
                        wb_valid_q  <= 1'b1;
                        wb_data_q   <= ld_ext_w;
                        wb_rd_idx_q <= rd_q;
                        state_q     <= S_DONE;
                    end else if (cnt_q == TO_LAST) begin
                        exc_valid_q <= 1'b1;
                        exc_cause_q <= EXC_TIMEOUT;
                        exc_addr_q  <= ea_q;
                        state_q     <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Bus fields are forced to zero outside an active request so idle outputs stay quiet.
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_req_q & is_store_q;
    assign mem_addr  = mem_req_q ? ea_q[ADDR_W+2:3] : '0;
    assign mem_be    = mem_req_q ? be_w : 8'h00;
    assign mem_wdata = mem_req_q ? wdata_w : 64'd0;

    assign ex_ready  = (state_q == S_IDLE);
    assign stall     = (state_q != S_IDLE);
    assign wb_valid  = wb_valid_q;
    assign wb_rd_idx = wb_rd_idx_q;
    assign wb_data   = wb_data_q;
    assign exc_valid = exc_valid_q;
    assign exc_cause = exc_cause_q;
    assign exc_addr  = exc_addr_q;

endmodule
